// File: rtl/regfile512_writer_n_pkg.sv
// regfile512_writer_n_pkg: shared sizes, sweep geometry and FSM state encoding.
package regfile512_writer_n_pkg;
   localparam int ADDR_W = 9;
   localparam int DEPTH = 2 ** ADDR_W;
   localparam int SWEEP_LANES = 4;
   localparam int SWEEP_CYCLES = DEPTH / SWEEP_LANES;
   typedef logic [0:0] state_t;
   localparam state_t IDLE = 1'b0;
   localparam state_t CLEAR = 1'b1;
   function automatic int group_of(input int idx);
      return idx / SWEEP_LANES;
   endfunction
endpackage

// File: rtl/regfile512_writer_n_if.sv
// regfile512_writer_n_if: write port, clear control and flat read-out of the register file.
interface regfile512_writer_n_if #(parameter int n = 4, parameter int address = 9);
   logic                 wr_valid_i;
   logic [address-1:0]   wr_addr_i;
   logic [n-1:0]         wr_data_i;
   logic                 wr_ready_o;
   logic                 clr_i;
   logic                 busy_o;
   logic                 clr_done_o;
   logic [n-1:0]         data_o [0:(2**address)-1];
   modport slave (
      input  wr_valid_i, wr_addr_i, wr_data_i, clr_i,
      output wr_ready_o, busy_o, clr_done_o, data_o
   );
   modport master (
      output wr_valid_i, wr_addr_i, wr_data_i, clr_i,
      input  wr_ready_o, busy_o, clr_done_o, data_o
   );
endinterface

// File: rtl/regfile512_writer_n_dec9to512.sv
// dec9to512: index plus enable to one-hot per-entry write enable.
module dec9to512 #(parameter int W = 9) (
   input  logic [W-1:0]      i_idx,
   input  logic              i_en,
   output logic [2**W-1:0]   o_onehot
);
   localparam int M = 2 ** W;
   always_comb o_onehot = i_en ? ({{(M-1){1'b0}}, 1'b1} << i_idx) : '0;
endmodule

// File: rtl/regfile512_writer_n.sv
// regfile512_writer_n: 512-entry register file with a single write port and a
// 4-entries-per-cycle clear sweep that blocks writes while it runs.
module regfile512_writer_n
   import regfile512_writer_n_pkg::*;
#(
   parameter int n = 4,
   parameter int address = ADDR_W
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   regfile512_writer_n_if.slave    bus
);
   localparam int M = 2 ** address;
   localparam int CW = $clog2(M / SWEEP_LANES);
   state_t         r_state;
   logic [CW-1:0]  r_cnt;
   logic [n-1:0]   r_mem [0:M-1];
   logic [M-1:0]   w_we;
   logic           w_clr;
   logic           w_last;
   assign w_clr = r_state == CLEAR;
   assign w_last = w_clr && (r_cnt == '1);
   assign bus.wr_ready_o = r_state == IDLE;
   assign bus.busy_o = w_clr;
   assign bus.clr_done_o = w_last;
   assign bus.data_o = r_mem;
   dec9to512 #(.W(address)) u_dec (
      .i_idx    (bus.wr_addr_i),
      .i_en     (bus.wr_valid_i && !w_clr),
      .o_onehot (w_we)
   );
   // the counter only rolls over on the exit edge, never inside a sweep
   always_ff @(posedge clk_i)
      if (rst_i) begin
         r_state <= IDLE;
         r_cnt <= '0;
      end else begin
         r_state <= w_clr ? (w_last ? IDLE : CLEAR) : (bus.clr_i ? CLEAR : IDLE);
         r_cnt <= w_clr ? r_cnt + 1'b1 : '0;
      end
   always_ff @(posedge clk_i)
      for (int i = 0; i < M; i++)
         if (rst_i || (w_clr && r_cnt == CW'(group_of(i)))) r_mem[i] <= '0;
         else if (w_we[i]) r_mem[i] <= bus.wr_data_i;
endmodule

// File: tb/tb_regfile512_writer_n.sv
// tb_regfile512_writer_n: table-driven writes with a scoreboard, plus sweep, collision and reset-abort sequences.
module tb_regfile512_writer_n;
   typedef struct { logic v; logic [8:0] a; logic [3:0] d; } vec_t;
   typedef struct { logic [8:0] a; logic [3:0] d; } sb_t;
   logic clk = 0;
   logic rst = 1;
   int checks = 0;
   int errors = 0;
   logic [3:0] exp_mem [0:511];
   sb_t sbq[$];
   vec_t tv[12];
   regfile512_writer_n_if #(.n(4), .address(9)) bus ();
   regfile512_writer_n #(.n(4), .address(9)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));
   always #5 clk = ~clk;
   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask
   task automatic cmp_all(input string nm);
      int bad = 0;
      for (int i = 0; i < 512; i++) if (bus.data_o[i] !== exp_mem[i]) bad++;
      check(nm, bad, 0);
   endtask
   task automatic zero_model();
      for (int i = 0; i < 512; i++) exp_mem[i] = 4'h0;
   endtask
   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end
   initial begin
      int n_done;
      bit fell;
      sb_t s;
      bus.wr_valid_i = 0; bus.wr_addr_i = '0; bus.wr_data_i = '0; bus.clr_i = 0;
      zero_model();
      repeat (2) @(negedge clk);
      rst = 0;
      check("rst_ready", bus.wr_ready_o, 1);
      check("rst_busy", bus.busy_o, 0);
      check("rst_done", bus.clr_done_o, 0);
      cmp_all("rst_data");
      tv[0] = '{1'b1, 9'h1FF, 4'hA};
      tv[1] = '{1'b1, 9'h000, 4'h1};
      tv[2] = '{1'b1, 9'h001, 4'h2};
      tv[3] = '{1'b1, 9'h002, 4'h3};
      tv[4] = '{1'b0, 9'h010, 4'h6};
      tv[5] = '{1'b1, 9'h100, 4'hC};
      tv[6] = '{1'b1, 9'h1FF, 4'h4};
      tv[7] = '{1'b1, 9'h0FF, 4'hE};
      for (int i = 8; i < 12; i++) tv[i] = '{1'b1, 9'($urandom_range(3, 511)), 4'($urandom_range(1, 15))};
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (sbq.size() > 0) begin
            s = sbq.pop_front();
            check($sformatf("wr_%0h", s.a), bus.data_o[s.a], s.d);
         end
         check("wr_ready", bus.wr_ready_o, 1);
         bus.wr_valid_i = tv[i].v; bus.wr_addr_i = tv[i].a; bus.wr_data_i = tv[i].d;
         if (tv[i].v) begin
            sbq.push_back('{tv[i].a, tv[i].d});
            exp_mem[tv[i].a] = tv[i].d;
         end
      end
      @(negedge clk);
      bus.wr_valid_i = 0;
      while (sbq.size() > 0) begin
         s = sbq.pop_front();
         check($sformatf("wr_%0h", s.a), bus.data_o[s.a], s.d);
      end
      cmp_all("table_all");
      for (int a = 0; a < 512; a++) begin
         @(negedge clk);
         bus.wr_valid_i = 1; bus.wr_addr_i = 9'(a); bus.wr_data_i = 4'hF;
         exp_mem[a] = 4'hF;
      end
      @(negedge clk);
      bus.wr_valid_i = 0;
      cmp_all("fill");
      bus.clr_i = 1;
      for (int c = 0; c < 128; c++) begin
         @(negedge clk);
         check($sformatf("sw_busy_%0d", c), bus.busy_o, 1);
         check($sformatf("sw_done_%0d", c), bus.clr_done_o, c == 127);
         check($sformatf("sw_ready_%0d", c), bus.wr_ready_o, 0);
         check($sformatf("sw_grp_%0d", c), bus.data_o[4*c], 4'hF);
         if (c > 0) check($sformatf("sw_prev_%0d", c), bus.data_o[4*c-1], 4'h0);
         bus.clr_i = (c == 50);
         bus.wr_valid_i = 1; bus.wr_addr_i = 9'h000; bus.wr_data_i = 4'h7;
      end
      @(negedge clk);
      bus.wr_valid_i = 0; bus.clr_i = 0;
      check("sw_end_busy", bus.busy_o, 0);
      check("sw_end_done", bus.clr_done_o, 0);
      check("sw_end_ready", bus.wr_ready_o, 1);
      zero_model();
      cmp_all("sw_end_data");
      bus.wr_valid_i = 1; bus.wr_addr_i = 9'h003; bus.wr_data_i = 4'h5; bus.clr_i = 1;
      @(negedge clk);
      bus.wr_valid_i = 0; bus.clr_i = 0;
      check("col_data", bus.data_o[3], 4'h5);
      check("col_busy", bus.busy_o, 1);
      @(negedge clk);
      check("col_cleared", bus.data_o[3], 4'h0);
      n_done = 0; fell = 0;
      for (int c = 0; c < 200 && !fell; c++) begin
         @(negedge clk);
         if (bus.clr_done_o) n_done++;
         if (!bus.busy_o) fell = 1;
      end
      check("col_end", fell, 1);
      check("col_done_once", n_done, 1);
      cmp_all("col_data_all");
      bus.wr_valid_i = 1; bus.wr_addr_i = 9'd100; bus.wr_data_i = 4'h9;
      @(negedge clk);
      bus.wr_valid_i = 0; bus.clr_i = 1;
      @(negedge clk);
      bus.clr_i = 0;
      n_done = 0;
      for (int c = 0; c < 60; c++) begin
         if (bus.clr_done_o) n_done++;
         @(negedge clk);
      end
      check("abort_busy_before", bus.busy_o, 1);
      rst = 1;
      bus.wr_valid_i = 1; bus.wr_addr_i = 9'd5; bus.wr_data_i = 4'h7; bus.clr_i = 1;
      @(negedge clk);
      rst = 0; bus.wr_valid_i = 0; bus.clr_i = 0;
      check("abort_busy", bus.busy_o, 0);
      check("abort_ready", bus.wr_ready_o, 1);
      check("abort_done", bus.clr_done_o, 0);
      cmp_all("abort_data");
      for (int c = 0; c < 140; c++) begin
         @(negedge clk);
         if (bus.clr_done_o || bus.busy_o) n_done++;
      end
      check("abort_no_done", n_done, 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
